dt_seq_classifier: RTL and testbench

- Programmable, sequential decision-tree classifier. Successor to the fixed, fully combinational per-dataset tree blocks.
- The tree topology, thresholds and leaf classes live in an internal node table, loaded through a config write port. One netlist therefore serves any tree up to NODES nodes and DEPTH levels.
- The engine walks one tree level per clock and uses a valid/ready handshake on both the feature input and the class output.
- It sits between the feature-capture front end and the result collector in the classifier datapath.

---
 rtl/dt_seq_classifier.sv | 135 +++++++++++++
 tb/tb_dt_seq_classifier.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_seq_classifier.sv
// Programmable sequential decision-tree classifier: walks one node of an
// internal, config-loaded node table per clock and returns a class or an error.
module dt_seq_classifier #(
    parameter int N     = 8,
    parameter int F     = 13,
    parameter int C     = 1,
    parameter int NODES = 64,
    parameter int DEPTH = 8,
    localparam int FW   = $clog2(F),
    localparam int AW   = $clog2(NODES),
    localparam int NW   = 1 + FW + N + 2 * AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [NW-1:0]    cfg_data,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [F*N-1:0]   features,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [C-1:0]     cls,
    output logic             err
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    typedef struct packed {
        logic          leaf;
        logic [FW-1:0] feat_idx;
        logic [N-1:0]  thresh;
        logic [AW-1:0] left;
        logic [AW-1:0] right;
    } node_t;

    state_t         r_state;
    state_t         w_next_state;
    node_t          r_table [NODES];
    logic [F*N-1:0] r_features;
    logic [AW-1:0]  r_node_ptr;
    logic [SW-1:0]  r_steps;
    logic [C-1:0]   r_cls;
    logic           r_err;

    node_t          w_node;
    logic [N-1:0]   w_feat_val;
    logic           w_bad_idx;
    logic           w_at_depth;
    logic           w_finish;

    assign w_node     = r_table[r_node_ptr];
    assign w_bad_idx  = int'(w_node.feat_idx) >= F;
    assign w_at_depth = int'(r_steps) == DEPTH - 1;
    assign w_finish   = w_node.leaf || w_bad_idx || w_at_depth;

    // Explicit mux keeps an out-of-range feature index from reading past the vector.
    always_comb begin
        w_feat_val = '0;
        for (int k = 0; k < F; k++) begin
            if (int'(w_node.feat_idx) == k) begin
                w_feat_val = r_features[k*N +: N];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_next_state = WALK;
            WALK: if (w_finish) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the node table is reset to zero on purpose, so an unprogrammed
    // engine yields a defined self-looping tree; this keeps it in flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                r_table[i] <= '0;
            end
            r_features <= '0;
            r_node_ptr <= '0;
            r_steps    <= '0;
            r_cls      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (cfg_we && r_state == IDLE) begin
                r_table[cfg_addr] <= node_t'(cfg_data);
            end
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_features <= features;
                        r_node_ptr <= '0;
                        r_steps    <= '0;
                    end
                end
                WALK: begin
                    if (w_node.leaf) begin
                        r_cls <= w_node.right[C-1:0];
                        r_err <= 1'b0;
                    end else if (w_bad_idx || w_at_depth) begin
                        r_cls <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_node_ptr <= (w_feat_val < w_node.thresh) ? w_node.left : w_node.right;
                        r_steps    <= r_steps + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign cfg_busy  = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign cls       = r_cls;
    assign err       = r_err;

endmodule

// File: tb/tb_dt_seq_classifier.sv
// Self-checking bench for dt_seq_classifier: table-driven vectors with a
// scoreboard queue, plus hand-written backpressure, config and reset sequences.
module tb_dt_seq_classifier;

    localparam int N     = 8;
    localparam int F     = 13;
    localparam int C     = 1;
    localparam int NODES = 64;
    localparam int DEPTH = 8;
    localparam int FW    = $clog2(F);
    localparam int AW    = $clog2(NODES);
    localparam int NW    = 1 + FW + N + 2 * AW;

    typedef struct packed {
        logic       cls;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    typedef struct packed {
        logic           tree_b;
        logic [F*N-1:0] feat;
        exp_t           e;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [NW-1:0]  cfg_data;
    logic           cfg_busy;
    logic           in_valid;
    logic           in_ready;
    logic [F*N-1:0] features;
    logic           out_valid;
    logic           out_ready;
    logic [C-1:0]   cls;
    logic           err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t vecs [10];

    dt_seq_classifier #(.N(N), .F(F), .C(C), .NODES(NODES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .features  (features),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cls       (cls),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [NW-1:0] node(input logic leaf, input logic [FW-1:0] fidx,
                                           input logic [N-1:0] thr, input logic [AW-1:0] l,
                                           input logic [AW-1:0] r);
        return {leaf, fidx, thr, l, r};
    endfunction

    function automatic logic [F*N-1:0] mkf(input logic [7:0] fill, input logic [7:0] f0,
                                           input logic [7:0] f2, input logic [7:0] f12);
        logic [F*N-1:0] v;
        v = {F{fill}};
        v[0*N +: N]  = f0;
        v[2*N +: N]  = f2;
        v[12*N +: N] = f12;
        return v;
    endfunction

    task automatic scramble_features();
        for (int k = 0; k < F; k++) features[k*N +: N] = 8'($urandom);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [NW-1:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Presents a vector (optionally with a simultaneous cfg write); returns 1ns after the accept edge.
    task automatic accept(input logic [F*N-1:0] f, input logic we,
                          input logic [AW-1:0] addr, input logic [NW-1:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        features = f; in_valid = 1'b1;
        cfg_we = we; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        scramble_features();
        check("in_ready_after_accept", in_ready, 0);
    endtask

    // Waits for the result, compares it with the scoreboard head, optionally
    // stalls out_ready for 'hold' cycles, then completes the handshake.
    task automatic collect(input string name, input int start_cyc, input int hold);
        int   cyc;
        exp_t e;
        cyc = start_cyc;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_latency"}, cyc, e.lat);
            check({name, "_cls"}, cls, e.cls);
            check({name, "_err"}, err, e.err);
            check({name, "_busy"}, cfg_busy, 1);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                in_valid = 1'b1;
                scramble_features();
                @(posedge clk); #1;
                check({name, "_hold_valid"}, out_valid, 1);
                check({name, "_hold_cls"}, cls, e.cls);
                check({name, "_hold_err"}, err, e.err);
                check({name, "_hold_in_ready"}, in_ready, 0);
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_out_valid_drop"}, out_valid, 0);
        check({name, "_in_ready_back"}, in_ready, 1);
        check({name, "_busy_clear"}, cfg_busy, 0);
    endtask

    task automatic send(input string name, input logic [F*N-1:0] f, input exp_t e);
        sb.push_back(e);
        accept(f, 1'b0, '0, '0);
        collect(name, 0, 0);
    endtask

    task automatic program_tree_a();
        wr(6'd0, node(1'b0, 4'd2, 8'd1, 6'd1, 6'd2));
        wr(6'd1, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd1));
        wr(6'd2, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0));
    endtask

    // Extends tree A: node2 becomes a split on feature 12, node5 a split on feature 0.
    task automatic program_tree_b();
        wr(6'd2, node(1'b0, 4'd12, 8'd200, 6'd4, 6'd5));
        wr(6'd4, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0));
        wr(6'd5, node(1'b0, 4'd0, 8'h80, 6'd6, 6'd7));
        wr(6'd6, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd1));
        wr(6'd7, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0));
    endtask

    initial begin
        bit b_loaded;

        vecs[0] = '{1'b0, mkf(8'h00, 8'h00, 8'h00, 8'h00),   '{1'b1, 1'b0, 8'd2}};
        vecs[1] = '{1'b0, mkf(8'h00, 8'h00, 8'h03, 8'h00),   '{1'b0, 1'b0, 8'd2}};
        vecs[2] = '{1'b0, mkf(8'h00, 8'h00, 8'h01, 8'h00),   '{1'b0, 1'b0, 8'd2}};
        vecs[3] = '{1'b0, mkf(8'h00, 8'h00, 8'hFF, 8'h00),   '{1'b0, 1'b0, 8'd2}};
        vecs[4] = '{1'b0, mkf(8'hFF, 8'hFF, 8'h00, 8'hFF),   '{1'b1, 1'b0, 8'd2}};
        vecs[5] = '{1'b1, mkf(8'h00, 8'h00, 8'h05, 8'd10),   '{1'b0, 1'b0, 8'd3}};
        vecs[6] = '{1'b1, mkf(8'h00, 8'h7F, 8'h05, 8'd200),  '{1'b1, 1'b0, 8'd4}};
        vecs[7] = '{1'b1, mkf(8'h00, 8'h80, 8'h05, 8'd200),  '{1'b0, 1'b0, 8'd4}};
        vecs[8] = '{1'b1, mkf(8'h00, 8'h00, 8'h01, 8'd199),  '{1'b0, 1'b0, 8'd3}};
        vecs[9] = '{1'b1, mkf(8'h00, 8'h00, 8'h00, 8'd255),  '{1'b1, 1'b0, 8'd2}};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; features = '0; out_ready = 1'b0;
        b_loaded = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_cls", cls, 0);
        check("rst_err", err, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        send("unprogrammed", mkf(8'h00, 8'h00, 8'h00, 8'h00), '{1'b0, 1'b1, 8'(DEPTH)});

        program_tree_a();
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].tree_b && !b_loaded) begin
                program_tree_b();
                b_loaded = 1'b1;
            end
            send($sformatf("vec%0d", i), vecs[i].feat, vecs[i].e);
        end

        // Out-of-range feature index under 10 cycles of backpressure.
        wr(6'd2, node(1'b0, 4'd13, 8'd0, 6'd0, 6'd0));
        sb.push_back('{1'b0, 1'b1, 8'd2});
        accept(mkf(8'h00, 8'h00, 8'h03, 8'h00), 1'b0, '0, '0);
        collect("bad_idx", 0, 10);

        // cfg write while walking is ignored.
        wr(6'd2, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0));
        sb.push_back('{1'b1, 1'b0, 8'd2});
        accept(mkf(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, '0, '0);
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0);
        check("walk_cfg_busy", cfg_busy, 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        collect("walk_write_ignored", 1, 0);

        // The same write in IDLE takes effect on the next vector.
        wr(6'd1, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd0));
        send("idle_write", mkf(8'h00, 8'h00, 8'h00, 8'h00), '{1'b0, 1'b0, 8'd2});

        // Write and accept on the same edge: new word used by this walk.
        sb.push_back('{1'b1, 1'b0, 8'd2});
        accept(mkf(8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 6'd1, node(1'b1, 4'd0, 8'd0, 6'd0, 6'd1));
        collect("same_cycle_write", 0, 0);

        // Reset at step 1 of a walk.
        accept(mkf(8'h00, 8'h00, 8'h05, 8'd200), 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midwalk_rst_out_valid", out_valid, 0);
        check("midwalk_rst_in_ready", in_ready, 1);
        check("midwalk_rst_busy", cfg_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        send("cleared_table", mkf(8'h00, 8'h00, 8'h00, 8'h00), '{1'b0, 1'b1, 8'(DEPTH)});
        program_tree_a();
        send("reprogrammed_left", mkf(8'h00, 8'h00, 8'h00, 8'h00), '{1'b1, 1'b0, 8'd2});
        send("reprogrammed_right", mkf(8'h00, 8'h00, 8'h03, 8'h00), '{1'b0, 1'b0, 8'd2});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
